ps2_key_state_tracker: RTL and testbench
========================================

PS2_KEY_STATE_TRACKER -- requirements
Module: ps2_key_state_tracker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the maximum number of cycles to wait after a prefix byte before abandoning the sequence.
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port ps2Byte, input, 8 bits: the received PS/2 scancode byte from the receiver.
REQ-005 SHALL have port ps2ByteValid, input, 1 bit: one-cycle strobe marking ps2Byte as valid.
REQ-006 SHALL have port keyState, output, 32 bits: the inputStateStorage vector; 1 means the key is held.
REQ-007 SHALL have port keyEvent, output, 1 bit: one-cycle pulse on each mapped make or break.
REQ-008 SHALL have port keyEventIndex, output, 5 bits: keyState index of the last event.
REQ-009 SHALL have port keyEventMake, output, 1 bit: 1 for a make event, 0 for a break event.
REQ-010 SHALL have port seqError, output, 1 bit: one-cycle pulse when a prefix sequence is abandoned by timeout.

Function
REQ-011 SHALL map non-extended codes to keyState indices as follows:
- 1C->0, 1D->1, 1B->2, 24->3, 23->4, 2B->5, 2C->6, 34->7
- 35->8, 33->9, 3C->10, 3B->11, 42->12, 29 (spacebar)->13, 5D (backslash)->14
REQ-012 SHALL map extended codes to keyState indices as follows: E0 6B (left arrow)->15, E0 74 (right arrow)->16.
REQ-013 SHALL hold keyState bits 17-31 at 0 at all times.
REQ-014 SHALL implement an FSM with states IDLE, EXT, BRK and EXTBRK; the FSM SHALL act only on cycles where ps2ByteValid=1.
REQ-015 In IDLE:
- E0 SHALL go to EXT.
- F0 SHALL go to BRK.
- AA SHALL clear all keyState bits in the next cycle, with no keyEvent.
- A mapped code SHALL be a make.
- Any other byte SHALL be ignored.
REQ-016 In EXT: F0 SHALL go to EXTBRK; any other byte SHALL be an extended make and return to IDLE.
REQ-017 In BRK: any byte SHALL be a non-extended break and return to IDLE.
REQ-018 In EXTBRK: any byte SHALL be an extended break and return to IDLE.
REQ-019 A make SHALL set the mapped bit; a break SHALL clear it; an unmapped code SHALL change nothing and produce no keyEvent.
REQ-020 Latency: keyState, keyEvent, keyEventIndex and keyEventMake SHALL update exactly 1 cycle after the ps2ByteValid cycle.
REQ-021 keyEventIndex and keyEventMake SHALL hold their values between events.
REQ-022 A repeated make (typematic) SHALL re-pulse keyEvent with keyEventMake=1; the bit SHALL stay 1.
REQ-023 A break for a key already released SHALL pulse keyEvent; the bit SHALL stay 0.
REQ-024 In EXT, BRK or EXTBRK, a cycle counter SHALL count cycles without ps2ByteValid.
REQ-025 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, pulse seqError for 1 cycle and leave keyState unchanged.
REQ-026 The timeout counter SHALL reset to 0 on every valid byte.
REQ-027 If a valid byte arrives on the same cycle the timeout expires, the byte SHALL win: it is processed normally and there is no seqError.
REQ-028 Back-to-back strobes on consecutive cycles SHALL each be processed; no byte is dropped.

Reset
REQ-029 While resetn=0, the block SHALL be asynchronously forced to: state IDLE, timeout counter 0, keyState 0, keyEvent 0, keyEventIndex 0, keyEventMake 0, seqError 0.
REQ-030 Reset asserted mid-sequence (e.g. after F0) SHALL discard the pending prefix, so the next byte after release is treated from IDLE.
REQ-031 Reset deassertion SHALL take effect on the first CLOCK_50 rising edge after resetn rises.

Configuration
REQ-032 Macro EXTENDED_KEYS_EN, when defined, SHALL enable the E0-prefixed mapping of REQ-012.
REQ-033 Without EXTENDED_KEYS_EN, E0 sequences SHALL still be fully consumed, including E0 F0 xx, but SHALL never change keyState or pulse keyEvent; bits 15-16 SHALL read 0.

Verification
REQ-034 Byte 29 -> 1 cycle later keyState[13]=1, keyEvent=1, keyEventIndex=13, keyEventMake=1; then F0 29 -> keyState[13]=0, keyEventMake=0.
REQ-035 Bytes 29, 5D, F0 29 -> keyState[14]=1 and keyState[13]=0; then AA -> keyState=0 with no keyEvent pulse.
REQ-036 With EXTENDED_KEYS_EN: E0 6B -> keyState[15]=1; E0 F0 6B -> keyState[15]=0. Without the macro, the same stimulus -> keyState stays 0 and there is no keyEvent.
REQ-037 F0 followed by no byte for TIMEOUT_CYCLES (set to 100) -> seqError pulses once at cycle 100; a following 1C -> keyState[0]=1 as a make.
REQ-038 Send F0, assert resetn=0 for 3 cycles, release, then send 1C -> keyState[0]=1 as a make (prefix discarded).
REQ-039 Back-to-back strobes 1C, 1D, 1B on consecutive cycles -> three keyEvent pulses with indices 0, 1, 2, and keyState[2:0]=111.

Source files
------------

// File: rtl/ps2_key_state_tracker.sv
// PS/2 scancode key-state tracker: decodes make/break/E0 sequences into a held-key vector.
// Optional build macro EXTENDED_KEYS_EN enables the E0-prefixed arrow-key mapping.
module ps2_key_state_tracker #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [7:0]  ps2Byte,
    input  logic        ps2ByteValid,
    output logic [31:0] keyState,
    output logic        keyEvent,
    output logic [4:0]  keyEventIndex,
    output logic        keyEventMake,
    output logic        seqError,
    output logic [1:0]  fsmState
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        EXTBRK = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [16:0]     key_state_q, key_state_d;
    logic            key_event_q, key_event_d;
    logic [4:0]      event_idx_q, event_idx_d;
    logic            event_make_q, event_make_d;
    logic            seq_error_q, seq_error_d;

    logic            do_key;
    logic            key_ext;
    logic            key_make;
    logic [5:0]      lookup;

    // Returns {hit, index}; hit=0 means the code is not tracked.
    function automatic logic [5:0] map_code(input logic [7:0] code, input logic ext);
        logic [5:0] r;
        r = 6'd0;
        if (!ext) begin
            case (code)
                8'h1C: r = {1'b1, 5'd0};
                8'h1D: r = {1'b1, 5'd1};
                8'h1B: r = {1'b1, 5'd2};
                8'h24: r = {1'b1, 5'd3};
                8'h23: r = {1'b1, 5'd4};
                8'h2B: r = {1'b1, 5'd5};
                8'h2C: r = {1'b1, 5'd6};
                8'h34: r = {1'b1, 5'd7};
                8'h35: r = {1'b1, 5'd8};
                8'h33: r = {1'b1, 5'd9};
                8'h3C: r = {1'b1, 5'd10};
                8'h3B: r = {1'b1, 5'd11};
                8'h42: r = {1'b1, 5'd12};
                8'h29: r = {1'b1, 5'd13};
                8'h5D: r = {1'b1, 5'd14};
                default: r = 6'd0;
            endcase
        end else begin
`ifdef EXTENDED_KEYS_EN
            case (code)
                8'h6B:   r = {1'b1, 5'd15};
                8'h74:   r = {1'b1, 5'd16};
                default: r = 6'd0;
            endcase
`else
            r = 6'd0;
`endif
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_state_d  = key_state_q;
        key_event_d  = 1'b0;
        event_idx_d  = event_idx_q;
        event_make_d = event_make_q;
        seq_error_d  = 1'b0;
        do_key       = 1'b0;
        key_ext      = 1'b0;
        key_make     = 1'b0;

        if (ps2ByteValid) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (ps2Byte == 8'hE0) begin
                        state_d = EXT;
                    end else if (ps2Byte == 8'hF0) begin
                        state_d = BRK;
                    end else if (ps2Byte == 8'hAA) begin
                        key_state_d = '0;
                    end else begin
                        do_key   = 1'b1;
                        key_make = 1'b1;
                    end
                end
                EXT: begin
                    if (ps2Byte == 8'hF0) begin
                        state_d = EXTBRK;
                    end else begin
                        do_key   = 1'b1;
                        key_ext  = 1'b1;
                        key_make = 1'b1;
                        state_d  = IDLE;
                    end
                end
                BRK: begin
                    do_key  = 1'b1;
                    state_d = IDLE;
                end
                EXTBRK: begin
                    do_key  = 1'b1;
                    key_ext = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A pending prefix is abandoned once the silence reaches the limit.
            if (cnt_q == CNT_LAST) begin
                state_d     = IDLE;
                cnt_d       = '0;
                seq_error_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        lookup = map_code(ps2Byte, key_ext);
        if (do_key && lookup[5]) begin
            key_event_d              = 1'b1;
            event_idx_d              = lookup[4:0];
            event_make_d             = key_make;
            key_state_d[lookup[4:0]] = key_make;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_state_q  <= '0;
            key_event_q  <= 1'b0;
            event_idx_q  <= 5'd0;
            event_make_q <= 1'b0;
            seq_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_state_q  <= key_state_d;
            key_event_q  <= key_event_d;
            event_idx_q  <= event_idx_d;
            event_make_q <= event_make_d;
            seq_error_q  <= seq_error_d;
        end
    end

    assign keyState      = {15'd0, key_state_q};
    assign keyEvent      = key_event_q;
    assign keyEventIndex = event_idx_q;
    assign keyEventMake  = event_make_q;
    assign seqError      = seq_error_q;
    assign fsmState      = state_q;

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Self-checking bench for ps2_key_state_tracker: directed scenarios plus random byte streams
// compared every cycle against a prefix-flag reference model.
module tb_ps2_key_state_tracker;

    localparam int TIMEOUT = 100;
`ifdef EXTENDED_KEYS_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    localparam logic [7:0] BASE_CODES [15] = '{
        8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34,
        8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h29, 8'h5D
    };
    localparam logic [7:0] EXT_CODES [2] = '{8'h6B, 8'h74};

    logic        CLOCK_50;
    logic        resetn;
    logic [7:0]  ps2Byte;
    logic        ps2ByteValid;
    logic [31:0] keyState;
    logic        keyEvent;
    logic [4:0]  keyEventIndex;
    logic        keyEventMake;
    logic        seqError;
    logic [1:0]  fsmState;

    ps2_key_state_tracker #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .ps2Byte       (ps2Byte),
        .ps2ByteValid  (ps2ByteValid),
        .keyState      (keyState),
        .keyEvent      (keyEvent),
        .keyEventIndex (keyEventIndex),
        .keyEventMake  (keyEventMake),
        .seqError      (seqError),
        .fsmState      (fsmState)
    );

    // clock / reset
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // reference model: held-key set plus pending-prefix flags
    logic [16:0] m_keys;
    bit          m_ext;
    bit          m_brk;
    int          m_silence;
    bit          exp_event;
    bit          exp_seqerr;
    logic [5:0]  exp_last;
    logic [5:0]  exp_q[$];

    function automatic int map_idx(input logic [7:0] b, input bit ext);
        if (!ext) begin
            for (int i = 0; i < 15; i++) if (BASE_CODES[i] == b) return i;
        end else if (EXT_EN) begin
            for (int i = 0; i < 2; i++) if (EXT_CODES[i] == b) return 15 + i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_keys = '0; m_ext = 0; m_brk = 0; m_silence = 0;
        exp_event = 0; exp_seqerr = 0; exp_last = '0;
        exp_q.delete();
    endtask

    task automatic model_apply(input logic [7:0] b, input bit ext, input bit make);
        int i;
        i = map_idx(b, ext);
        if (i >= 0) begin
            m_keys[i] = make;
            exp_event = 1;
            exp_last  = {make, 5'(i)};
            exp_q.push_back(exp_last);
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        exp_event = 0; exp_seqerr = 0;
        if (v) begin
            m_silence = 0;
            if (!m_ext && !m_brk) begin
                if (b == 8'hE0)      m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else if (b == 8'hAA) m_keys = '0;
                else                 model_apply(b, 0, 1);
            end else if (m_ext && !m_brk) begin
                if (b == 8'hF0) m_brk = 1;
                else begin model_apply(b, 1, 1); m_ext = 0; end
            end else begin
                model_apply(b, m_ext, 0);
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_silence++;
            if (m_silence == TIMEOUT) begin
                m_ext = 0; m_brk = 0; m_silence = 0; exp_seqerr = 1;
            end
        end
    endtask

    // driver: called at a negedge, returns at the following negedge
    task automatic step(input bit v, input logic [7:0] b);
        logic [5:0] got;
        ps2ByteValid = v;
        ps2Byte      = b;
        model_step(v, b);
        @(posedge CLOCK_50);
        #1;
        ps2ByteValid = 1'b0;
        check("key_state", keyState, {15'd0, m_keys});
        check("key_event", {31'd0, keyEvent}, {31'd0, exp_event});
        check("seq_error", {31'd0, seqError}, {31'd0, exp_seqerr});
        check("evt_hold", {26'd0, keyEventMake, keyEventIndex}, {26'd0, exp_last});
        if (keyEvent) begin
            if (exp_q.size() == 0) check("evt_q_size", 32'(exp_q.size()), 32'd1);
            else begin
                got = exp_q.pop_front();
                check("evt_id", {26'd0, keyEventMake, keyEventIndex}, {26'd0, got});
            end
        end else if (exp_event && exp_q.size() > 0) begin
            void'(exp_q.pop_back());
        end
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        ps2ByteValid = 1'b0;
        #1;
        check("rst_state", keyState, 32'd0);
        check("rst_event", {29'd0, keyEvent, keyEventMake, seqError}, 32'd0);
        check("rst_index", {27'd0, keyEventIndex}, 32'd0);
        model_reset();
        repeat (cycles) @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b);
    endtask

    initial begin
        int n;
        bit found;
        int r;
        logic [7:0] b;
        resetn = 1'b0; ps2Byte = 8'h00; ps2ByteValid = 1'b0;
        model_reset();
        @(negedge CLOCK_50);
        do_reset(2);

        // spacebar make then break
        send(8'h29);
        check("space_make_idx", {27'd0, keyEventIndex}, 32'd13);
        send(8'hF0); send(8'h29);
        check("space_break", {31'd0, keyState[13]}, 32'd0);

        // two keys, one released, then self-test clear
        send(8'h29); send(8'h5D); send(8'hF0); send(8'h29);
        check("bs_held", keyState, 32'h0000_4000);
        send(8'hAA);
        check("aa_clear", keyState, 32'd0);

        // extended arrow make/break (model follows build macro)
        send(8'hE0); send(8'h6B);
        check("ext_make", {31'd0, keyState[15]}, {31'd0, EXT_EN});
        send(8'hE0); send(8'hF0); send(8'h6B);
        check("ext_break", {31'd0, keyState[15]}, 32'd0);
        send(8'hE0); send(8'hF0); send(8'h74);
        send(8'h1C);

        // typematic repeat and redundant break
        send(8'h1D); send(8'h1D);
        send(8'hF0); send(8'h1B); send(8'hF0); send(8'h1B);

        // timeout after F0
        do_reset(2);
        send(8'hF0);
        n = 0; found = 0;
        while (!found && n < 2 * TIMEOUT) begin
            step(0, 8'h00);
            n++;
            if (seqError) found = 1;
        end
        check("timeout_len", n, TIMEOUT);
        send(8'h1C);
        check("after_timeout", {31'd0, keyState[0]}, 32'd1);

        // byte arriving on the expiry cycle wins
        send(8'hF0);
        repeat (TIMEOUT - 1) step(0, 8'h00);
        send(8'h1C);
        check("byte_wins", {31'd0, keyState[0]}, 32'd0);

        // reset mid-sequence discards the prefix
        send(8'hF0);
        do_reset(3);
        send(8'h1C);
        check("rst_prefix", {31'd0, keyState[0]}, 32'd1);

        // back-to-back strobes
        do_reset(1);
        send(8'h1C); send(8'h1D); send(8'h1B);
        check("b2b_bits", {29'd0, keyState[2:0]}, 32'd7);

        // random streams
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 79) == 0) begin
                n = $urandom_range(TIMEOUT - 3, TIMEOUT + 3);
                repeat (n) step(0, 8'h00);
            end
            r = $urandom_range(0, 19);
            if (r < 9)       b = BASE_CODES[$urandom_range(0, 14)];
            else if (r < 11) b = EXT_CODES[$urandom_range(0, 1)];
            else if (r < 13) b = 8'hE0;
            else if (r < 16) b = 8'hF0;
            else if (r < 17) b = 8'hAA;
            else             b = 8'($urandom_range(0, 255));
            step($urandom_range(0, 2) != 0, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
